// File: rtl/inst_sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok instruction interface.
// Word-addressed memory with in-order responses after a fixed latency and bounded outstanding depth.
module inst_sram_like_responder #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MEM_AW          = 12,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic                wr,
   input  logic [1:0]          size,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                stall,
   output logic                addr_ok,
   output logic                data_ok,
   output logic [DATA_W-1:0]   rdata
);

   localparam int NB = DATA_W / 8;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = $clog2(LATENCY + 1);
   localparam logic [TW-1:0] T_INIT  = TW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

   logic [MEM_AW-1:0]  idx;
   logic [CW-1:0]      cnt_q, cnt_d, slot;
   logic               push, pop;
   logic [TW-1:0]      timer_q [MAX_OUTSTANDING];
   logic [TW-1:0]      timer_d [MAX_OUTSTANDING];
   logic [DATA_W-1:0]  data_q  [MAX_OUTSTANDING];
   logic [DATA_W-1:0]  data_src[MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] load;
   logic [DATA_W-1:0]  snap;
   logic               unused_bits;

   assign unused_bits = ^{size, addr};
   assign idx         = addr[MEM_AW+1:2];

   // A full queue refuses even if its head retires this same cycle.
   assign addr_ok = !rst && req && !stall && (cnt_q < CNT_MAX);
   assign push    = req && addr_ok;
   assign pop     = (cnt_q != '0) && (timer_q[0] == '0);
   assign data_ok = !rst && pop;
   assign rdata   = data_ok ? data_q[0] : '0;

   assign slot = pop ? cnt_q - CW'(1) : cnt_q;
   assign snap = wr ? '0 : mem[idx];

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Each slot takes its successor on a pop; timers run down regardless of position.
   for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_ent
      logic [TW-1:0] t_src;
      if (gi < MAX_OUTSTANDING - 1) begin : g_mid
         assign t_src        = pop ? timer_q[gi+1] : timer_q[gi];
         assign data_src[gi] = pop ? data_q[gi+1]  : data_q[gi];
      end else begin : g_last
         assign t_src        = timer_q[gi];
         assign data_src[gi] = data_q[gi];
      end
      assign load[gi] = push && (slot == CW'(gi));

      always_comb begin
         timer_d[gi] = (t_src != '0) ? t_src - TW'(1) : t_src;
         if (load[gi]) begin
            timer_d[gi] = T_INIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            timer_q[i] <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            timer_q[i] <= timer_d[i];
            data_q[i]  <= load[i] ? snap : data_src[i];
         end
      end
   end

   // Memory is deliberately left out of reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (push && wr) begin
         for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) begin
               mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_sram_like_responder.sv
// Randomised scoreboard bench for inst_sram_like_responder against a queue/array reference model.
module tb_inst_sram_like_responder;

   localparam int LAT = 2;
   localparam int MO  = 2;

   logic        clk = 1'b0;
   logic        rst, req, wr, stall;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   inst_sram_like_responder #(
      .ADDR_W(32), .DATA_W(32), .MEM_AW(12), .LATENCY(LAT), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .stall(stall),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
   );

   typedef struct {
      logic [31:0] data;
      int          due;
      logic        w;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem_m [0:4095];
   int          cyc      = 0;
   int          last_due = 0;
   int          checks   = 0;
   int          errors   = 0;
   logic        acc_exp  = 1'b0;
   int          idx_tab[8] = '{0, 1, 4, 5, 100, 2048, 4094, 4095};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: an accepted request lands in a FIFO with its due cycle,
   // which is the later of accept+LAT and one past the previous response.
   exp_t e_new;
   int   wi;
   always @(posedge clk) begin
      if (rst) begin
         last_due = 0;
      end else if (acc_exp) begin
         wi = int'(addr[13:2]);
         e_new.w = wr;
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (wstrb[b]) mem_m[wi][b*8 +: 8] = wdata[b*8 +: 8];
            e_new.data = 32'h0;
         end else begin
            e_new.data = mem_m[wi];
         end
         e_new.due = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
         last_due  = e_new.due;
         sb.push_back(e_new);
      end
   end

   // Monitor: compare outputs mid-cycle, pop on every data_ok.
   exp_t e_got;
   always @(negedge clk) begin
      cyc++;
      acc_exp = !rst && req && !stall && (sb.size() < MO);
      chk("addr_ok", {31'b0, addr_ok}, {31'b0, acc_exp});
      if (rst) begin
         chk("rst_data_ok", {31'b0, data_ok}, 32'h0);
         chk("rst_rdata", rdata, 32'h0);
         sb.delete();
      end else if (data_ok) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_data_ok cyc=%0d got=1 expected=0", cyc);
         end else begin
            e_got = sb.pop_front();
            chk("rdata", rdata, e_got.data);
            chk("latency", cyc, e_got.due);
            $display("resp cyc=%0d %s rdata=%h", cyc, e_got.w ? "wr" : "rd", rdata);
         end
      end else begin
         chk("idle_rdata", rdata, 32'h0);
         if (sb.size() > 0) begin
            checks++;
            if (sb[0].due <= cyc) begin
               errors++;
               $display("FAIL missed_data_ok cyc=%0d got=0 expected due at %0d", cyc, sb[0].due);
            end
         end
      end
   end

   task automatic drive(input logic r, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic st, input logic rs);
      @(posedge clk);
      #1;
      req   = r;
      wr    = w;
      wstrb = s;
      addr  = a;
      wdata = d;
      stall = st;
      rst   = rs;
      size  = 2'($urandom_range(0, 3));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] a;
      int          ix;
      rst = 1'b1; req = 1'b1; wr = 1'b0; stall = 1'b0; size = 2'd2;
      wstrb = 4'h0; addr = 32'h10; wdata = 32'h0;

      // Reset held with req asserted.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1);

      // Give every word the bench touches a defined value.
      for (int i = 0; i < 8; i++) begin
         ix = idx_tab[i];
         a  = {18'h0, ix[11:0], 2'b00};
         drive(1'b1, 1'b1, 4'hF, a, $urandom, 1'b0, 1'b0);
         idle(1);
      end
      idle(3);

      // Full write then read-back, then a single-byte merge via an aliased address.
      drive(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0);
      idle(4);
      drive(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, 1'b0, 1'b0);
      idle(1);
      drive(1'b1, 1'b0, 4'h0, 32'hF0004013, 32'h0, 1'b0, 1'b0);
      idle(4);

      // Back-pressure from a full queue.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0);
      idle(4);

      // External stall.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0, 1'b0);
      idle(4);

      // Reset with reads in flight; memory must survive.
      drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1);
      idle(3);
      drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0);
      idle(4);

      // Random traffic over the pre-initialised words with random alias bits.
      for (int i = 0; i < 400; i++) begin
         a  = $urandom;
         ix = idx_tab[$urandom_range(0, 7)];
         a[13:2] = ix[11:0];
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
               4'($urandom_range(0, 15)), a, $urandom,
               ($urandom_range(0, 9) < 2), ($urandom_range(0, 199) == 0));
      end
      idle(10);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
